// File: rtl/mod_exp_ctrl_if.sv
// Operand/strobe bundle between the exponentiation sequencer and the shared mod_operation unit.
// The sequencer is the master: it issues operands, the mod unit answers with a result strobe.
interface mod_exp_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             mod_ena;
  logic [WIDTH-1:0] mod_a;
  logic [WIDTH-1:0] mod_b;
  logic [WIDTH-1:0] mod_res;
  logic             mod_write;

  modport master (
    output mod_ena, mod_a, mod_b,
    input  mod_res, mod_write
  );

  modport slave (
    input  mod_ena, mod_a, mod_b,
    output mod_res, mod_write
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Right-to-left square-and-multiply sequencer: result = base^exp mod modulus, with every
// reduction delegated to one external mod unit and the products formed combinationally here.
module mod_exp_ctrl #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 16,
  parameter int EXP_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [OP_W-1:0]  mod_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [OP_W-1:0]  result,
  mod_exp_ctrl_if.master   mod
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RED_ISSUE,
    S_RED_WAIT,
    S_CHECK,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_SQR_ISSUE,
    S_SQR_WAIT,
    S_FINISH
  } state_t;

  state_t           r_state;
  logic [OP_W-1:0]  r_b;
  logic [OP_W-1:0]  r_r;
  logic [EXP_W-1:0] r_e;
  logic [OP_W-1:0]  r_m;
  logic             r_err_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [OP_W-1:0]  r_result;
  logic             r_mod_ena;
  logic [WIDTH-1:0] r_mod_a;
  logic [WIDTH-1:0] r_mod_b;

  logic [2*OP_W-1:0] w_prod_rb;
  logic [2*OP_W-1:0] w_prod_bb;
  logic [OP_W-1:0]   w_one_mod;
  logic [OP_W-1:0]   w_res_lo;
  logic              w_exp_last;
  logic              w_unused;

  assign w_prod_rb  = (2*OP_W)'(r_r) * (2*OP_W)'(r_b);
  assign w_prod_bb  = (2*OP_W)'(r_b) * (2*OP_W)'(r_b);
  // 1 mod m is 0 only for m == 1; m == 0 never reaches the datapath
  assign w_one_mod  = (r_m == OP_W'(1)) ? '0 : OP_W'(1);
  assign w_res_lo   = mod.mod_res[OP_W-1:0];
  assign w_exp_last = (r_e[EXP_W-1:1] == '0);
  assign w_unused   = ^mod.mod_res[WIDTH-1:OP_W];

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign result      = r_result;
  assign mod.mod_ena = r_mod_ena;
  assign mod.mod_a   = r_mod_a;
  assign mod.mod_b   = r_mod_b;

  // mod_ena/mod_a are loaded on the edge that enters an ISSUE state, so the pulse
  // coincides with the ISSUE cycle and the operands stay put through the WAIT state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_b        <= '0;
      r_r        <= '0;
      r_e        <= '0;
      r_m        <= '0;
      r_err_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= '0;
      r_mod_ena  <= 1'b0;
      r_mod_a    <= '0;
      r_mod_b    <= '0;
    end else begin
      r_mod_ena <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_e    <= exp_in;
            r_m    <= mod_in;
            r_busy <= 1'b1;
            r_err  <= 1'b0;
            if (mod_in == '0) begin
              r_err_pend <= 1'b1;
              r_r        <= '0;
              r_state    <= S_FINISH;
            end else if (exp_in == '0) begin
              r_err_pend <= 1'b0;
              r_r        <= (mod_in == OP_W'(1)) ? '0 : OP_W'(1);
              r_state    <= S_FINISH;
            end else begin
              r_err_pend <= 1'b0;
              r_mod_ena  <= 1'b1;
              r_mod_a    <= base_in;
              r_mod_b    <= WIDTH'(mod_in);
              r_state    <= S_RED_ISSUE;
            end
          end
        end
        S_RED_ISSUE: r_state <= S_RED_WAIT;
        S_RED_WAIT: begin
          if (mod.mod_write) begin
            r_b     <= w_res_lo;
            r_r     <= w_one_mod;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_mod_ena <= 1'b1;
          if (r_e[0]) begin
            r_mod_a <= WIDTH'(w_prod_rb);
            r_state <= S_MUL_ISSUE;
          end else begin
            r_mod_a <= WIDTH'(w_prod_bb);
            r_state <= S_SQR_ISSUE;
          end
        end
        S_MUL_ISSUE: r_state <= S_MUL_WAIT;
        S_MUL_WAIT: begin
          if (mod.mod_write) begin
            r_r <= w_res_lo;
            // the final multiply is not followed by a (useless) squaring
            if (w_exp_last) begin
              r_state <= S_FINISH;
            end else begin
              r_mod_ena <= 1'b1;
              r_mod_a   <= WIDTH'(w_prod_bb);
              r_state   <= S_SQR_ISSUE;
            end
          end
        end
        S_SQR_ISSUE: r_state <= S_SQR_WAIT;
        S_SQR_WAIT: begin
          if (mod.mod_write) begin
            r_b     <= w_res_lo;
            r_e     <= r_e >> 1;
            r_state <= S_CHECK;
          end
        end
        S_FINISH: begin
          r_done   <= 1'b1;
          r_result <= r_r;
          r_err    <= r_err_pend;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Randomised bench for mod_exp_ctrl: behavioural mod unit with random latency, arithmetic
// reference for base^exp mod m and for the expected number of mod operations.
module tb_mod_exp_ctrl;
  localparam int WIDTH = 32;
  localparam int OP_W  = 16;
  localparam int EXP_W = 16;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             start   = 1'b0;
  logic [WIDTH-1:0] base_in = '0;
  logic [EXP_W-1:0] exp_in  = '0;
  logic [OP_W-1:0]  mod_in  = '0;
  logic             busy, done, err;
  logic [OP_W-1:0]  result;

  mod_exp_ctrl_if #(.WIDTH(WIDTH)) mif();

  mod_exp_ctrl #(.WIDTH(WIDTH), .OP_W(OP_W), .EXP_W(EXP_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .base_in(base_in), .exp_in(exp_in), .mod_in(mod_in),
    .busy(busy), .done(done), .err(err), .result(result),
    .mod(mif)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // mod-unit model state
  int               ena_cnt   = 0;
  int               hs_viol   = 0;
  int               force_at  = -1;
  int               force_lat = 0;
  int               cnt       = 0;
  bit               pend      = 1'b0;
  bit               killed    = 1'b0;
  logic [WIDTH-1:0] pa, pb;
  logic [WIDTH-1:0] issue_a[$];
  logic [WIDTH-1:0] issue_b[$];

  // Mod unit: latches operands on mod_ena, answers a % b after 1..40 cycles, and
  // flags any new issue or operand change while an op is outstanding.
  initial begin
    mif.mod_write = 1'b0;
    mif.mod_res   = '0;
    forever begin
      @(negedge clock);
      mif.mod_write = 1'b0;
      if (pend) begin
        if (!reset_n) killed = 1'b1;
        if (!killed && (mif.mod_a !== pa || mif.mod_b !== pb)) hs_viol++;
        if (mif.mod_ena === 1'b1) hs_viol++;
        if (cnt == 0) begin
          mif.mod_res   = pa % pb;
          mif.mod_write = 1'b1;
          pend          = 1'b0;
        end else begin
          cnt--;
        end
      end else if (mif.mod_ena === 1'b1) begin
        ena_cnt++;
        issue_a.push_back(mif.mod_a);
        issue_b.push_back(mif.mod_b);
        pa     = mif.mod_a;
        pb     = mif.mod_b;
        pend   = 1'b1;
        killed = 1'b0;
        if (ena_cnt == force_at) cnt = force_lat - 1;
        else                     cnt = int'($urandom_range(40, 1)) - 1;
      end
    end
  end

  function automatic longint ref_pow(longint b, longint e, longint m);
    longint r;
    if (m == 0) return 0;
    r = 1 % m;
    b = b % m;
    while (e > 0) begin
      if (e % 2 == 1) r = (r * b) % m;
      e = e / 2;
      b = (b * b) % m;
    end
    return r;
  endfunction

  function automatic int ref_ops(longint e, longint m);
    int pop, len;
    if (m == 0 || e == 0) return 0;
    pop = 0; len = 0;
    while (e > 0) begin
      pop += int'(e % 2);
      len++;
      e = e / 2;
    end
    return 1 + pop + (len - 1);
  endfunction

  logic [OP_W-1:0] got_res;
  logic            got_err;
  int              got_ops, got_lat;
  bit              got_gap, got_dnext, got_tmo;

  task automatic run_op(input logic [WIDTH-1:0] b, input logic [EXP_W-1:0] e,
                        input logic [OP_W-1:0] m);
    int e0;
    e0 = ena_cnt;
    issue_a.delete();
    issue_b.delete();
    @(negedge clock);
    base_in = b; exp_in = e; mod_in = m; start = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    base_in = $urandom; exp_in = EXP_W'($urandom); mod_in = OP_W'($urandom);
    got_lat = 1; got_gap = 1'b0; got_tmo = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (done === 1'b1) begin got_tmo = 1'b0; break; end
      if (busy !== 1'b1) got_gap = 1'b1;
      @(negedge clock);
      got_lat++;
    end
    got_res = result;
    got_err = err;
    got_ops = ena_cnt - e0;
    @(negedge clock);
    got_dnext = (done === 1'b1);
  endtask

  task automatic test_reset;
    int e0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags busy/done/err=%b required 000", {busy, done, err});
    end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result got %0d required 0", result); end
    checks++;
    if (mif.mod_ena !== 1'b0 || mif.mod_a !== '0 || mif.mod_b !== '0) begin
      errors++; $display("FAIL reset_mod ena=%b a=%0d b=%0d required 0", mif.mod_ena, mif.mod_a, mif.mod_b);
    end
    // start together with reset: reset wins
    e0 = ena_cnt;
    base_in = 4; exp_in = 13; mod_in = 497; start = 1'b1;
    @(negedge clock);
    start = 1'b0; reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || ena_cnt != e0) begin
      errors++; $display("FAIL reset_vs_start busy=%b ops=%0d required 0 0", busy, ena_cnt - e0);
    end
  endtask

  task automatic test_vectors;
    int unsigned vb[3], ve[3], vm[3], vr[3], vo[3];
    vb = '{4, 65, 2790};
    ve = '{13, 17, 2753};
    vm = '{497, 3233, 3233};
    vr = '{445, 2790, 65};
    vo = '{7, 7, 17};
    for (int k = 0; k < 3; k++) begin
      run_op(WIDTH'(vb[k]), EXP_W'(ve[k]), OP_W'(vm[k]));
      checks++;
      if (got_tmo) begin errors++; $display("FAIL vec%0d_timeout no done within bound", k); end
      checks++;
      if (got_res !== OP_W'(vr[k]) || got_err !== 1'b0) begin
        errors++; $display("FAIL vec%0d_result got %0d err=%b required %0d err=0", k, got_res, got_err, vr[k]);
      end
      checks++;
      if (got_ops != int'(vo[k])) begin
        errors++; $display("FAIL vec%0d_ops got %0d required %0d", k, got_ops, vo[k]);
      end
      checks++;
      if (got_gap || got_dnext) begin
        errors++; $display("FAIL vec%0d_busy_done busy_dropped=%b done_extra=%b required 0 0", k, got_gap, got_dnext);
      end
    end
  endtask

  task automatic test_single_mul;
    run_op(6051600, 1, 4819);
    checks++;
    if (got_tmo || got_res !== 16'd3755) begin
      errors++; $display("FAIL single_mul_result got %0d timeout=%b required 3755", got_res, got_tmo);
    end
    checks++;
    if (got_ops != 2) begin errors++; $display("FAIL single_mul_ops got %0d required 2", got_ops); end
    checks++;
    if (issue_a.size() == 0 || issue_a[0] !== 32'd6051600 || issue_b[0] !== 32'd4819) begin
      errors++; $display("FAIL single_mul_first_issue size=%0d required a=6051600 b=4819", issue_a.size());
    end
  endtask

  task automatic test_trivial;
    run_op($urandom, 0, 497);
    checks++;
    if (got_res !== 16'd1 || got_err !== 1'b0 || got_ops != 0 || got_lat != 2) begin
      errors++; $display("FAIL exp0_m497 res=%0d err=%b ops=%0d lat=%0d required 1 0 0 2", got_res, got_err, got_ops, got_lat);
    end
    run_op($urandom, 0, 1);
    checks++;
    if (got_res !== 16'd0 || got_ops != 0 || got_lat != 2) begin
      errors++; $display("FAIL exp0_m1 res=%0d ops=%0d lat=%0d required 0 0 2", got_res, got_ops, got_lat);
    end
    run_op($urandom, 5, 0);
    checks++;
    if (got_err !== 1'b1 || got_res !== 16'd0 || got_ops != 0 || got_lat != 2) begin
      errors++; $display("FAIL mod0 err=%b res=%0d ops=%0d lat=%0d required 1 0 0 2", got_err, got_res, got_ops, got_lat);
    end
    run_op(3, 4, 7);
    checks++;
    if (got_err !== 1'b0 || got_res !== 16'd4) begin
      errors++; $display("FAIL err_clear err=%b res=%0d required 0 4", got_err, got_res);
    end
  endtask

  task automatic test_busy_start;
    int e0, ops0;
    bit seen, extra;
    e0 = ena_cnt;
    force_at = e0 + 3; force_lat = 12;
    @(negedge clock);
    base_in = 4; exp_in = 13; mod_in = 497; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (ena_cnt >= e0 + 3) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL busy_start_reach_sqr issues=%0d required 3", ena_cnt - e0); end
    @(negedge clock);
    base_in = 9; exp_in = 3; mod_in = 11; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done === 1'b1) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!seen || result !== 16'd445 || ena_cnt - e0 != 7) begin
      errors++; $display("FAIL busy_start_result done=%b res=%0d ops=%0d required 1 445 7", seen, result, ena_cnt - e0);
    end
    ops0 = ena_cnt; extra = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra || ena_cnt != ops0) begin
      errors++; $display("FAIL busy_start_queued activity=%b ops=%0d required 0 0", extra, ena_cnt - ops0);
    end
    force_at = -1;
  endtask

  task automatic test_reset_mid;
    int e0, ops0;
    bit seen, stray;
    e0 = ena_cnt;
    force_at = e0 + 2; force_lat = 30;
    @(negedge clock);
    base_in = 65; exp_in = 17; mod_in = 3233; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (ena_cnt >= e0 + 2) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_mid_reach_mul issues=%0d required 2", ena_cnt - e0); end
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, done, err} !== 3'b000 || result !== '0 || mif.mod_ena !== 1'b0 ||
        mif.mod_a !== '0 || mif.mod_b !== '0) begin
      errors++; $display("FAIL reset_mid_outputs bde=%b res=%0d ena=%b a=%0d b=%0d required all 0",
                         {busy, done, err}, result, mif.mod_ena, mif.mod_a, mif.mod_b);
    end
    reset_n = 1'b1;
    ops0 = ena_cnt;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #1;
      if (!pend) begin seen = 1'b1; break; end
    end
    stray = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || mif.mod_a !== '0) stray = 1'b1;
    end
    checks++;
    if (!seen || stray || ena_cnt != ops0) begin
      errors++; $display("FAIL reset_mid_stray strobe_seen=%b disturbed=%b ops=%0d required 1 0 0", seen, stray, ena_cnt - ops0);
    end
    force_at = -1;
    run_op(65, 17, 3233);
    checks++;
    if (got_tmo || got_res !== 16'd2790 || got_ops != 7) begin
      errors++; $display("FAIL reset_mid_next res=%0d ops=%0d timeout=%b required 2790 7 0", got_res, got_ops, got_tmo);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] b;
    logic [EXP_W-1:0] e;
    logic [OP_W-1:0]  m;
    longint           exp_r;
    int               exp_o;
    for (int k = 0; k < 15; k++) begin
      b = $urandom;
      m = ($urandom_range(3, 0) == 0) ? OP_W'($urandom_range(20, 1)) : OP_W'($urandom);
      e = ($urandom_range(3, 0) == 0) ? EXP_W'($urandom_range(8, 0)) : EXP_W'($urandom);
      exp_r = ref_pow(longint'(b), longint'(e), longint'(m));
      exp_o = ref_ops(longint'(e), longint'(m));
      run_op(b, e, m);
      checks++;
      if (got_tmo || got_res !== OP_W'(exp_r) || got_err !== (m == '0) || got_ops != exp_o) begin
        errors++; $display("FAIL rand%0d b=%0d e=%0d m=%0d got res=%0d err=%b ops=%0d required %0d %b %0d",
                           k, b, e, m, got_res, got_err, got_ops, exp_r, (m == '0), exp_o);
      end
    end
  endtask

  task automatic test_handshake;
    checks++;
    if (hs_viol != 0) begin
      errors++; $display("FAIL handshake violations=%0d required 0", hs_viol);
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_single_mul;
    test_trivial;
    test_busy_start;
    test_reset_mid;
    test_random;
    test_handshake;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
